wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Wishbone classic-cycle master that sits directly upstream of the 4-register, 8-bit Wishbone slaves in this design and drives their bus. It accepts register commands from a local valid/ready stream, buffers them in a small FIFO, and issues one Wishbone cycle per command. It waits for ack with a bounded timeout and returns one response per command on a valid/ready output stream.

## Interface
Parameters:
- FIFO_DEPTH, 4: command FIFO entries; a power of two, 2..16.
- TIMEOUT, 15: maximum cycles a bus cycle may wait for ack; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_n_i  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  FIFO can accept a command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  2  register address.
- cmd_dat_i  in  8  write data; ignored for reads.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_dat_o  out  8  read data, or echoed write data.
- rsp_err_o  out  1  bus cycle timed out.
- wb_adr_o  out  2  Wishbone address.
- wb_dat_o  out  8  Wishbone write data.
- wb_dat_i  in  8  Wishbone read data.
- wb_we_o  out  1  Wishbone write enable.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_ack_i  in  1  Wishbone acknowledge; may be combinational from stb/cyc.
- busy_o  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

## Operation
- **Command FIFO**
  - A command {we, adr, dat} is pushed on each rising edge where cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = !full. It is registered from the occupancy count.
  - Push and pop in the same cycle is allowed; occupancy stays unchanged.
  - A push attempt while full is ignored and no entry is lost.
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, BUS, RSP.
- **IDLE**
  - If the FIFO is non-empty, the head is popped at the edge. wb_adr_o, wb_dat_o and wb_we_o load from it, and wb_cyc_o and wb_stb_o go high. Go to BUS.
  - Otherwise stay in IDLE.
- **BUS**
  - Address, data and we are held stable.
  - The timeout counter clears on entry to BUS and increments each cycle in BUS.
  - On wb_ack_i sampled high:
    - cyc and stb drop at that edge.
    - For a read, rsp_dat_o <= wb_dat_i. For a write, rsp_dat_o <= the written data.
    - rsp_err_o <= 0, rsp_valid_o <= 1. Go to RSP.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with ack low:
    - cyc and stb drop.
    - rsp_dat_o <= 0, rsp_err_o <= 1, rsp_valid_o <= 1. Go to RSP.
  - Ack wins over timeout in the same cycle.
- **RSP**
  - Outputs are held until rsp_valid_o && rsp_ready_i at an edge.
  - At that edge rsp_valid_o <= 0, then go to IDLE.
  - No new bus cycle starts while a response is pending.
- **Ignored inputs:** wb_ack_i is ignored in IDLE and RSP. wb_dat_i is sampled only on ack in BUS.
- **Counter width:** the timeout counter is clog2(TIMEOUT+1) bits and saturates. It never wraps.

## Timing
- **Reset values:** while wb_rst_n_i is low, all outputs are 0 (cmd_ready_o = 0 during reset, 1 from the first edge after deassertion), the FIFO is empty and the FSM is in IDLE.
- **Reset mid-operation:** assertion drops wb_cyc_o and wb_stb_o asynchronously and discards queued commands and any pending response.
- **Zero-wait slave (combinational ack)**
  - Command accepted at edge E0.
  - cyc/stb high after E1.
  - Ack sampled at E2; cyc/stb low and rsp_valid_o high after E2.
  - With rsp_ready_i high, the response is consumed at E3 and the next command's cyc starts after E4.
  - Steady-state throughput is one command per 3 cycles.
- **Wait states:** each cycle ack is held low extends BUS by one cycle.
- **Timeout:** with TIMEOUT=N and no ack, cyc/stb are high for exactly N cycles.
- **Back-to-back cycles:** cyc and stb are always deasserted for at least 2 cycles between bus cycles.

## Test plan
- **Write then read back:** reset, then push write adr=1 dat=0xA5 and read adr=1 against the logic slave.
  - Write response: dat=0xA5, err=0.
  - Read response: dat=0xA5, err=0.
  - cyc high exactly 1 cycle per command.
- **Computed registers:** write 0xF0 to adr 0 and 0x3C to adr 1, then read adr 2 and adr 3.
  - Read adr 2 returns 0x30.
  - Read adr 3 returns 0xFC.
- **FIFO full and backpressure:** hold rsp_ready_i=0 and push 6 commands with FIFO_DEPTH=4.
  - cmd_ready_o is low after 5 accepts: 4 in the FIFO, 1 in flight.
  - Release rsp_ready_i: all 5 responses arrive in order, and the 6th is accepted once space frees.
- **Timeout:** TIMEOUT=15, ack tied low, read adr 0.
  - cyc high exactly 15 cycles.
  - Response dat=0x00, err=1.
  - The next command proceeds normally.
- **Wait states:** ack delayed 3 cycles.
  - cyc high 4 cycles; adr, dat and we stable throughout.
  - Response err=0.
- **Reset mid-cycle:** assert wb_rst_n_i while in BUS with 2 commands queued.
  - cyc and stb are 0 immediately, before the next edge.
  - After release: rsp_valid_o=0, busy_o=0, and no stale cycles are issued.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle master fed by a buffered valid/ready command stream.
// Latency: command accepted at E0 -> cyc/stb after E1 -> response after ack edge (E2 for zero-wait slave).
// Backpressure: cmd_ready_o drops when the FIFO is full; a pending response blocks new bus cycles.
module wb_cmd_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_we_i,
  input  logic [1:0] cmd_adr_i,
  input  logic [7:0] cmd_dat_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_dat_o,
  output logic       rsp_err_o,
  output logic [1:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i,
  output logic       busy_o
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  // A zero TIMEOUT would give a zero-width counter; keep one bit that is never consulted.
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);
  localparam logic [TW-1:0]   TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0]   TMO_SAT  = TW'((TIMEOUT > 0) ? TIMEOUT : 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO: entries are {we, adr[1:0], dat[7:0]}
  // ---------------------------------------------------------------------------
  logic [10:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic            ready_q;
  logic            push;
  logic            pop;
  logic [10:0]     head;

  // FSM registers
  state_e          state_q;
  logic [TW-1:0]   tmo_q;
  logic            cyc_q;
  logic            stb_q;
  logic            we_q;
  logic [1:0]      adr_q;
  logic [7:0]      dat_q;
  logic            rsp_valid_q;
  logic [7:0]      rsp_dat_q;
  logic            rsp_err_q;

  assign push = cmd_valid_i && ready_q;
  assign pop  = (state_q == ST_IDLE) && (cnt_q != '0);
  assign head = mem_q[rd_ptr_q];

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers and occupancy; ready is registered from the next occupancy so it is exact.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != FULL_CNT);
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_we_i, cmd_adr_i, cmd_dat_i};
  end

  // ---------------------------------------------------------------------------
  // Bus FSM: one Wishbone cycle per command, one response per cycle.
  // ---------------------------------------------------------------------------
  // Single registered FSM; all bus and response outputs come straight from flops.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            we_q    <= head[10];
            adr_q   <= head[9:8];
            dat_q   <= head[7:0];
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= ST_BUS;
          end
        end

        ST_BUS: begin
          if (wb_ack_i) begin
            // Ack has priority over a timeout landing in the same cycle.
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_dat_q   <= we_q ? dat_q : wb_dat_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end else if (tmo_q != TMO_SAT) begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        ST_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign busy_o      = (state_q != ST_IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master against a 4-register logic slave.
// Slave: reg0/reg1 writable, reg2 = reg0 & reg1, reg3 = reg0 | reg1.
// Ack is combinational, optionally delayed by wait_n cycles or tied low.
module tb_wb_cmd_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [1:0] cmd_adr;
  logic [7:0] cmd_dat;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_dat;
  logic [1:0] wb_adr;
  logic [7:0] wb_wdat, wb_rdat;
  logic       wb_we, wb_stb, wb_cyc, wb_ack, busy;

  always #5 clk = ~clk;

  wb_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wb_adr_o   (wb_adr),
    .wb_dat_o   (wb_wdat),
    .wb_dat_i   (wb_rdat),
    .wb_we_o    (wb_we),
    .wb_stb_o   (wb_stb),
    .wb_cyc_o   (wb_cyc),
    .wb_ack_i   (wb_ack),
    .busy_o     (busy)
  );

  // ---------------- slave model ----------------
  logic [7:0] sregs [4];
  int         wcnt = 0;
  int         wait_n = 0;
  logic       tie_low = 1'b0;

  assign wb_ack = wb_cyc && wb_stb && !tie_low && (wcnt == wait_n);

  always_comb begin
    wb_rdat = 8'h00;
    case (wb_adr)
      2'd0: wb_rdat = sregs[0];
      2'd1: wb_rdat = sregs[1];
      2'd2: wb_rdat = sregs[0] & sregs[1];
      default: wb_rdat = sregs[0] | sregs[1];
    endcase
  end

  always @(posedge clk) begin
    if (wb_cyc && wb_stb && !wb_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (wb_cyc && wb_stb && wb_we && wb_ack) sregs[wb_adr] <= wb_wdat;
  end

  // ---------------- bus monitor (negedge) ----------------
  int         edge_n = 0;
  int         run = 0, last_len = 0, gap = 0, min_gap = 1000, ncyc = 0;
  logic       seen_any = 1'b0, unstable = 1'b0;
  logic [1:0] cap_adr = 2'd0;
  logic [7:0] cap_dat = 8'd0;
  logic       cap_we = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (wb_cyc) begin
      if (run == 0) begin
        ncyc    <= ncyc + 1;
        cap_adr <= wb_adr;
        cap_dat <= wb_wdat;
        cap_we  <= wb_we;
        if (seen_any && gap < min_gap) min_gap <= gap;
      end else if (wb_adr !== cap_adr || wb_wdat !== cap_dat || wb_we !== cap_we || wb_stb !== 1'b1) begin
        unstable <= 1'b1;
      end
      run <= run + 1;
    end else begin
      if (run != 0) begin
        last_len <= run;
        seen_any <= 1'b1;
        gap      <= 1;
      end else begin
        gap <= gap + 1;
      end
      run <= 0;
    end
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad = 0;
  int acc_edge = 0;
  int rsp_edge = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [1:0] adr, input logic [7:0] dat, input string tag);
    int n = 0;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " accept"}, 32'(cmd_ready), 1);
    @(posedge clk); #1;
    acc_edge = edge_n;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [7:0] ed, input logic ee, input string tag);
    int n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    rsp_edge = edge_n;
    check({tag, " valid"}, 32'(rsp_valid), 1);
    check({tag, " dat"}, 32'(rsp_dat), 32'(ed));
    check({tag, " err"}, 32'(rsp_err), 32'(ee));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc_w;
    int r1_edge;
    int n_before;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 2'd0; cmd_dat = 8'd0; rsp_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", 32'(cmd_ready), 0);
    check("rst cyc", 32'(wb_cyc), 0);
    check("rst stb", 32'(wb_stb), 0);
    check("rst rsp_valid", 32'(rsp_valid), 0);
    check("rst busy", 32'(busy), 0);
    rst_n = 1'b1;
    #1;
    check("ready before first edge", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    check("ready after first edge", 32'(cmd_ready), 1);

    // Write then read back, zero-wait slave
    push(1'b1, 2'd1, 8'hA5, "wr1");
    acc_w = acc_edge;
    push(1'b0, 2'd1, 8'h00, "rd1");
    get_rsp(8'hA5, 1'b0, "wr1 rsp");
    check("wr1 latency", 32'(rsp_edge - acc_w), 2);
    check("wr1 cyc len", 32'(last_len), 1);
    r1_edge = rsp_edge;
    get_rsp(8'hA5, 1'b0, "rd1 rsp");
    check("rd1 spacing", 32'(rsp_edge - r1_edge), 3);
    check("rd1 cyc len", 32'(last_len), 1);

    // Computed registers
    push(1'b1, 2'd0, 8'hF0, "w0");
    push(1'b1, 2'd1, 8'h3C, "w1");
    push(1'b0, 2'd2, 8'h00, "r2");
    push(1'b0, 2'd3, 8'h00, "r3");
    get_rsp(8'hF0, 1'b0, "w0 rsp");
    get_rsp(8'h3C, 1'b0, "w1 rsp");
    get_rsp(8'h30, 1'b0, "r2 rsp");
    get_rsp(8'hFC, 1'b0, "r3 rsp");

    // FIFO full and backpressure
    rsp_ready = 1'b0;
    push(1'b1, 2'd0, 8'h11, "f1");
    push(1'b1, 2'd1, 8'h22, "f2");
    push(1'b0, 2'd0, 8'h00, "f3");
    push(1'b0, 2'd1, 8'h00, "f4");
    push(1'b1, 2'd0, 8'h55, "f5");
    check("full ready", 32'(cmd_ready), 0);
    check("full busy", 32'(busy), 1);
    check("full rsp pending", 32'(rsp_valid), 1);
    cmd_we = 1'b0; cmd_adr = 2'd3; cmd_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("full still blocked", 32'(cmd_ready), 0);
    fork
      push(1'b0, 2'd3, 8'h00, "f6");
      begin
        get_rsp(8'h11, 1'b0, "f1 rsp");
        get_rsp(8'h22, 1'b0, "f2 rsp");
        get_rsp(8'h11, 1'b0, "f3 rsp");
        get_rsp(8'h22, 1'b0, "f4 rsp");
        get_rsp(8'h55, 1'b0, "f5 rsp");
      end
    join
    get_rsp(8'h77, 1'b0, "f6 rsp");

    // Timeout with ack tied low
    tie_low = 1'b1;
    push(1'b0, 2'd0, 8'h00, "tmo");
    get_rsp(8'h00, 1'b1, "tmo rsp");
    check("tmo cyc len", 32'(last_len), 15);
    tie_low = 1'b0;
    push(1'b0, 2'd0, 8'h00, "after tmo");
    get_rsp(8'h55, 1'b0, "after tmo rsp");
    check("after tmo cyc len", 32'(last_len), 1);

    // Wait states: ack after 3 extra cycles
    wait_n = 3;
    push(1'b1, 2'd1, 8'h9C, "ws");
    get_rsp(8'h9C, 1'b0, "ws rsp");
    check("ws cyc len", 32'(last_len), 4);
    check("ws stable", 32'(unstable), 0);

    // Reset mid-cycle with two commands queued
    wait_n = 12;
    push(1'b1, 2'd0, 8'hAA, "rm1");
    push(1'b1, 2'd1, 8'hBB, "rm2");
    push(1'b1, 2'd0, 8'hCC, "rm3");
    check("rm in bus", 32'(wb_cyc), 1);
    check("rm busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm cyc async", 32'(wb_cyc), 0);
    check("rm stb async", 32'(wb_stb), 0);
    check("rm ready", 32'(cmd_ready), 0);
    n_before = ncyc;
    wait_n = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("rm rsp_valid", 32'(rsp_valid), 0);
    check("rm busy after", 32'(busy), 0);
    check("rm no stale", 32'(ncyc - n_before), 0);
    check("rm ready after", 32'(cmd_ready), 1);
    push(1'b0, 2'd0, 8'h00, "post rst rd0");
    get_rsp(8'h55, 1'b0, "post rst rd0 rsp");
    push(1'b0, 2'd1, 8'h00, "post rst rd1");
    get_rsp(8'h9C, 1'b0, "post rst rd1 rsp");

    check("min gap ok", 32'(min_gap >= 2), 1);
    check("stable overall", 32'(unstable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
